// File: rtl/dmem_pkg.sv
// Shared constants and the read-return tag for the cluster data-memory front end.
package dmem_pkg;

  localparam int DEF_NUM_C = 4;
  localparam int DEF_DW    = 16;
  localparam int DEF_AW    = 16;

  // Tag index is sized for the largest cluster we expect to build (256 cores).
  localparam int TAG_IDX_W = 8;

  // Describes the read issued at the last edge. At most one read is in flight
  // because memory latency is exactly one cycle.
  typedef struct packed {
    logic                 valid;
    logic                 is_com;
    logic [TAG_IDX_W-1:0] idx;
  } rd_tag_t;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter.sv
// Round-robin arbiter: masks requests, searches upward from the pointer
// (modulo N), issues a one-hot grant and advances the pointer past the winner.
// Handshake: a request is granted combinationally in the cycle it is eligible
// and en_i is high; the pointer moves only on the edge that ends a grant cycle.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic          gnt_any_o,
  output logic [PW-1:0] gnt_idx_o,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  elig;

  assign elig  = req_i & mask_i;
  assign ptr_o = ptr_q;

  // Position k steps above p, wrapping at N (works for non-power-of-2 N).
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  // First eligible requester at or after the pointer wins.
  always_comb begin
    logic [PW-1:0] cand;
    gnt_o     = '0;
    gnt_any_o = 1'b0;
    gnt_idx_o = '0;
    cand      = '0;
    if (en_i) begin
      for (int k = 0; k < N; k++) begin
        cand = wrap_add(ptr_q, k);
        if (!gnt_any_o && elig[cand]) begin
          gnt_any_o   = 1'b1;
          gnt_o[cand] = 1'b1;
          gnt_idx_o   = cand;
        end
      end
    end
  end

  // Next pointer sits just above the winner; unchanged without a grant.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_o) begin
      ptr_d = (gnt_idx_o == PW'(N - 1)) ? '0 : gnt_idx_o + PW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory front end shared by NUM_C cores and the com port.
// Com has absolute priority; cores are served round-robin. Reads are tagged
// so the one-cycle-late memory data is flagged valid only to its requester.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NUM_C = DEF_NUM_C,
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_C-1:0]         core_active,
  input  logic [NUM_C-1:0]         core_req,
  input  logic [NUM_C-1:0]         core_we,
  input  logic [NUM_C*AW-1:0]      core_addr,
  input  logic [NUM_C*DW-1:0]      core_wdata,
  output logic [NUM_C-1:0]         core_gnt,
  output logic [NUM_C-1:0]         core_rvalid,
  output logic [DW-1:0]            core_rdata,
  input  logic                     com_req,
  input  logic                     com_we,
  input  logic [AW-1:0]            com_addr,
  input  logic [DW-1:0]            com_wdata,
  output logic                     com_gnt,
  output logic                     com_rvalid,
  output logic [DW-1:0]            com_rdata,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic [DW-1:0]            mem_rdata,
  output logic [$clog2(NUM_C)-1:0] dbg_rr_ptr_o
);

  localparam int PW = $clog2(NUM_C);

  logic          core_en;
  logic          core_any;
  logic [PW-1:0] core_idx;

  logic          win_any;
  logic          win_we;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  rd_tag_t       tag_q, tag_d;

  // Cores compete only when com is idle and the block is out of reset.
  assign core_en = rst_n & ~com_req;
  assign com_gnt = rst_n & com_req;

  rr_arbiter #(.N(NUM_C), .PW(PW)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (core_req),
    .mask_i    (core_active),
    .en_i      (core_en),
    .gnt_o     (core_gnt),
    .gnt_any_o (core_any),
    .gnt_idx_o (core_idx),
    .ptr_o     (dbg_rr_ptr_o)
  );

  // Steer the winner onto the memory port; with no winner the last address
  // and data stay on the bus and the write strobe drops.
  always_comb begin
    win_any = com_gnt | core_any;
    win_we  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (com_gnt) begin
      win_we  = com_we;
      addr_d  = com_addr;
      wdata_d = com_wdata;
    end else if (core_any) begin
      win_we  = core_we[core_idx];
      addr_d  = core_addr[core_idx*AW +: AW];
      wdata_d = core_wdata[core_idx*DW +: DW];
    end
  end

  assign mem_we    = win_we;
  assign mem_addr  = addr_d;
  assign mem_wdata = wdata_d;

  // Record who issued a read this cycle so the return can be routed.
  always_comb begin
    tag_d        = '0;
    tag_d.valid  = win_any & ~win_we;
    tag_d.is_com = com_gnt;
    tag_d.idx    = TAG_IDX_W'(core_idx);
  end

  // Held bus values and the read tag; reset drops any pending read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tag_q   <= tag_d;
    end
  end

  // Decode the tag into the one-hot read-valid flags.
  always_comb begin
    core_rvalid = '0;
    for (int i = 0; i < NUM_C; i++) begin
      core_rvalid[i] = tag_q.valid & ~tag_q.is_com & (tag_q.idx == TAG_IDX_W'(i));
    end
  end

  assign com_rvalid = tag_q.valid & tag_q.is_com;
  assign core_rdata = mem_rdata;
  assign com_rdata  = mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Parametrised shared data-memory front end for the multi-core cluster. It replaces per-core DRAM ports with a single memory port. Per cycle it grants one of NUM_C cores or the external com port, with round-robin fairness among cores and absolute priority for com. It tags reads so the 1-cycle-latency return data reaches only the requester.

Parameters:
NUM_C, 4, number of core request channels (>=2)
DW, 16, data width
AW, 16, address width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
core_active  in  NUM_C  per-core enable (n_cores style); inactive cores are masked from arbitration
core_req  in  NUM_C  per-core access request, held until granted
core_we  in  NUM_C  per-core write enable qualifying core_req
core_addr  in  NUM_C*AW  packed addresses, core i at [i*AW +: AW]
core_wdata  in  NUM_C*DW  packed write data, core i at [i*DW +: DW]
core_gnt  out  NUM_C  one-hot grant, combinational, same cycle as request
core_rvalid  out  NUM_C  one-hot read-data-valid, registered
core_rdata  out  DW  read data broadcast to all cores, valid where core_rvalid set
com_req, com_we  in  1  external/loader access request and write enable
com_addr  in  AW  external address
com_wdata  in  DW  external write data
com_gnt  out  1  external grant
com_rvalid  out  1  external read-data-valid
com_rdata  out  DW  external read data
mem_we  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, registered in memory, valid 1 cycle after address

Behaviour:
- Eligible set E = core_req & core_active.
- Priority: com_req wins unconditionally. Otherwise grant the first set bit of E at or after rr_ptr, searching upward modulo NUM_C. At most one grant is asserted per cycle.
- Memory drive, all combinational from the winner: mem_addr/mem_wdata = winner's fields; mem_we = winner's we.
- No winner: mem_we=0; mem_addr and mem_wdata hold their last driven values. This needs a registered copy.
- rr_ptr (clog2(NUM_C) bits), resets to 0. On a core grant to index g, rr_ptr <= (g+1) mod NUM_C at the clock edge. It is unchanged on a com grant or idle cycle.
- Fairness: without com traffic, a continuously requesting active core is granted within NUM_C cycles.
- Read return: a granted read with we=0 records a tag {valid, is_com, index} at the edge. Next cycle, the tagged requester's rvalid is 1 for exactly one cycle. core_rdata = com_rdata = mem_rdata, passed through.
- Writes produce no rvalid. Back-to-back reads by different requesters give rvalid on consecutive cycles with no bubbles.
- core_active falling while core_req is held: the request is ignored. A read already granted still returns its rvalid next cycle.
- Widths: no arithmetic on data. rr_ptr wraps at NUM_C-1 -> 0, including non-power-of-2 NUM_C.
- Reset (rst_n=0 at edge): rr_ptr=0, tag valid=0, all rvalid=0, held mem_addr/mem_wdata=0. Grants are still combinational from inputs. mem_we is forced 0 and all grants forced 0 while rst_n=0. A pending read during reset is dropped.

Decomposition:
- Package dmem_pkg: default DW/AW/NUM_C constants and the read-tag struct {valid, is_com, idx}.
- Sub-module rr_arbiter (params N) holds the request mask, the rotate-from-pointer priority search, one-hot grant and the pointer update. It is reused later for the instruction memory.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all reqs=1 -> all gnt=0, mem_we=0, rvalid=0. Then release with core_req=4'b1111 -> first gnt=4'b0001.
- Round-robin: core_req=4'b1111 and all active for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... Each core is written once per 4 cycles.
- Com priority: com_req=1, com_we=0, com_addr=0x0010 while cores request -> com_gnt=1, core_gnt=0, and com_rvalid=1 next cycle with mem_rdata. rr_ptr is unchanged, so the next core grant goes to the same core as without the com cycle.
- Masking: core_active=4'b0101, core_req=4'b1111 -> grants alternate 0001,0100 only.
- Read tagging: core 2 reads 0x0042 (memory preloaded 0xBEEF), then core 3 reads the next cycle -> core_rvalid=0100 with rdata 0xBEEF, then 1000. Write grants give no rvalid.
- Reset mid-read: grant a core 1 read, assert rst_n=0 on the next edge -> core_rvalid stays 0 and rr_ptr=0.
